// File: rtl/ifq_fetch_seq.sv
// Instruction fetch sequencer.
// Requests one 128-bit cache line at a time, then drains it word by word
// into the instruction FIFO. When the FIFO is empty and dispatch is waiting,
// a word can go straight to dispatch instead of through the FIFO.
// A branch redirect flushes everything and refetches from the target.
module ifq_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    output logic [31:0]  pc_in,
    output logic         cache_rd_en,
    output logic         cache_abort,
    input  logic [127:0] dout,
    input  logic         dout_valid,
    output logic         push,
    output logic [31:0]  push_data,
    output logic [31:0]  push_pc,
    input  logic         fifo_full,
    input  logic         fifo_empty,
    input  logic         inst_rd_en,
    output logic         pop,
    output logic         bypass,
    input  logic [31:0]  jmp_branch_address,
    input  logic         jmp_branch_valid,
    output logic         flush,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   fetch_pc_s;
    logic [127:0]  line_buf_r;
    logic [127:0]  line_buf_s;
    logic [1:0]    idx_s;
    logic          push_s;
    logic          bypass_s;
    logic          pop_s;
    logic          flush_s;
    logic          abort_s;
    logic          unused_addr_s;

    // Select 32-bit word k out of a cache line.
    function automatic logic [31:0] line_word(input logic [127:0] line,
                                              input logic [1:0]   k);
        logic [31:0] w;
        case (k)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            2'd3:    w = line[127:96];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // The word index is simply the word offset of the fetch address.
    assign idx_s = fetch_pc_r[3:2];

    // Redirect targets are word aligned; the byte offset bits are dropped.
    assign unused_addr_s = ^jmp_branch_address[1:0];

    // Next-state, next-data and strobe decode; redirect overrides everything.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        line_buf_s = line_buf_r;
        push_s     = 1'b0;
        bypass_s   = 1'b0;
        pop_s      = 1'b0;
        flush_s    = 1'b0;
        abort_s    = 1'b0;
        if (reset) begin
            // Inputs are ignored while reset is held; the register block
            // loads the reset values.
            state_s = IDLE;
        end else if (jmp_branch_valid) begin
            flush_s    = 1'b1;
            abort_s    = (state_r == REQ);
            fetch_pc_s = {jmp_branch_address[31:2], 2'b00};
            // The flush empties the FIFO, so fifo_full is irrelevant here.
            state_s    = REQ;
        end else begin
            pop_s = inst_rd_en & ~fifo_empty;
            case (state_r)
                IDLE: begin
                    if (!fifo_full) begin
                        state_s = REQ;
                    end else begin
                        state_s = IDLE;
                    end
                end
                REQ: begin
                    if (dout_valid) begin
                        line_buf_s = dout;
                        state_s    = DRAIN;
                    end else begin
                        state_s = REQ;
                    end
                end
                DRAIN: begin
                    if (!fifo_full) begin
                        if (fifo_empty && inst_rd_en) begin
                            bypass_s = 1'b1;
                        end else begin
                            push_s = 1'b1;
                        end
                        fetch_pc_s = fetch_pc_r + 32'd4;
                        // A delivery only happens with room in the FIFO,
                        // so finishing the line always goes straight to REQ.
                        if (idx_s == 2'd3) begin
                            state_s = REQ;
                        end else begin
                            state_s = DRAIN;
                        end
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, fetch address and line buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            line_buf_r <= 128'h0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            line_buf_r <= line_buf_s;
        end
    end

    assign state       = state_r;
    assign cache_rd_en = (state_r == REQ);
    assign pc_in       = {fetch_pc_r[31:4], 4'b0000};
    assign push_data   = line_word(line_buf_r, idx_s);
    assign push_pc     = fetch_pc_r;
    assign push        = push_s;
    assign bypass      = bypass_s;
    assign pop         = pop_s;
    assign flush       = flush_s;
    assign cache_abort = abort_s;

endmodule

// File: tb/tb_ifq_fetch_seq.sv
// Bench for ifq_fetch_seq: a directed vector table, a wrap-around sequence
// on a second instance, and a randomized run against a transaction model.
module tb_ifq_fetch_seq;

    localparam logic [127:0] LINE = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

    logic         clk;
    logic         reset;
    logic [127:0] dout;
    logic         dout_valid;
    logic         fifo_full;
    logic         fifo_empty;
    logic         inst_rd_en;
    logic [31:0]  jmp_branch_address;
    logic         jmp_branch_valid;

    logic [31:0]  pc_in_a, push_data_a, push_pc_a;
    logic         cache_rd_en_a, cache_abort_a, push_a, pop_a, bypass_a, flush_a;
    logic [1:0]   state_a;
    logic [31:0]  pc_in_b, push_data_b, push_pc_b;
    logic         cache_rd_en_b, cache_abort_b, push_b, pop_b, bypass_b, flush_b;
    logic [1:0]   state_b;

    int total = 0;
    int bad   = 0;

    ifq_fetch_seq dut_a (
        .clk(clk), .reset(reset), .pc_in(pc_in_a), .cache_rd_en(cache_rd_en_a),
        .cache_abort(cache_abort_a), .dout(dout), .dout_valid(dout_valid),
        .push(push_a), .push_data(push_data_a), .push_pc(push_pc_a),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .inst_rd_en(inst_rd_en),
        .pop(pop_a), .bypass(bypass_a), .jmp_branch_address(jmp_branch_address),
        .jmp_branch_valid(jmp_branch_valid), .flush(flush_a), .state(state_a)
    );

    ifq_fetch_seq #(.RESET_PC(32'hFFFF_FFF0)) dut_b (
        .clk(clk), .reset(reset), .pc_in(pc_in_b), .cache_rd_en(cache_rd_en_b),
        .cache_abort(cache_abort_b), .dout(dout), .dout_valid(dout_valid),
        .push(push_b), .push_data(push_data_b), .push_pc(push_pc_b),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .inst_rd_en(inst_rd_en),
        .pop(pop_b), .bypass(bypass_b), .jmp_branch_address(jmp_branch_address),
        .jmp_branch_valid(jmp_branch_valid), .flush(flush_b), .state(state_b)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst, full, empty, rd, dv, jbv;
        logic [31:0] jaddr;
        logic [1:0]  st;
        logic        rd_en, abort, push, byp, pop, flush;
        logic [31:0] pcin, pd, ppc;
    } vec_t;

    vec_t vecs[$];

    // Observable outputs packed together; data/pc only matter on a delivery.
    function automatic logic [103:0] pk(input logic [1:0] st, input logic rd_en,
                                        input logic abort, input logic psh,
                                        input logic byp, input logic pp,
                                        input logic fl, input logic [31:0] pcin,
                                        input logic [31:0] pd, input logic [31:0] ppc);
        logic dl;
        dl = psh | byp;
        return {st, rd_en, abort, psh, byp, pp, fl, pcin,
                dl ? pd : 32'h0, dl ? ppc : 32'h0};
    endfunction

    function automatic logic [103:0] act_a();
        return pk(state_a, cache_rd_en_a, cache_abort_a, push_a, bypass_a, pop_a,
                  flush_a, pc_in_a, push_data_a, push_pc_a);
    endfunction

    function automatic logic [103:0] act_b();
        return pk(state_b, cache_rd_en_b, cache_abort_b, push_b, bypass_b, pop_b,
                  flush_b, pc_in_b, push_data_b, push_pc_b);
    endfunction

    task automatic chk(input string name, input logic [103:0] got, input logic [103:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic full, input logic empty,
                         input logic rd, input logic dv, input logic jbv,
                         input logic [31:0] ja, input logic [127:0] d);
        reset = rst; fifo_full = full; fifo_empty = empty; inst_rd_en = rd;
        dout_valid = dv; jmp_branch_valid = jbv; jmp_branch_address = ja; dout = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic rst, input logic full, input logic empty,
                       input logic rd, input logic dv, input logic jbv,
                       input logic [31:0] ja, input logic [1:0] st,
                       input logic rd_en, input logic abort, input logic psh,
                       input logic byp, input logic pp, input logic fl,
                       input logic [31:0] pcin, input logic [31:0] pd,
                       input logic [31:0] ppc);
        vec_t v;
        v.rst = rst; v.full = full; v.empty = empty; v.rd = rd; v.dv = dv;
        v.jbv = jbv; v.jaddr = ja; v.st = st; v.rd_en = rd_en; v.abort = abort;
        v.push = psh; v.byp = byp; v.pop = pp; v.flush = fl; v.pcin = pcin;
        v.pd = pd; v.ppc = ppc;
        vecs.push_back(v);
    endtask

    // Transaction-level model: fetch address, current line, and whether a
    // line request is outstanding or a line is being handed out.
    logic [31:0] m_pc;
    logic [31:0] m_words [4];
    logic        m_wait, m_have;

    function automatic logic [103:0] model_exp(input logic rst, input logic full,
                                               input logic empty, input logic rd,
                                               input logic jbv);
        logic [1:0] st;
        logic dl, byp, psh;
        st  = m_have ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
        dl  = !rst && m_have && !full && !jbv;
        byp = dl && empty && rd;
        psh = dl && !byp;
        return pk(st, m_wait, !rst && jbv && m_wait, psh, byp,
                  !rst && rd && !empty && !jbv, !rst && jbv,
                  m_pc & 32'hFFFF_FFF0, m_words[m_pc[3:2]], m_pc);
    endfunction

    task automatic model_step(input logic rst, input logic full, input logic dv,
                              input logic jbv, input logic [31:0] ja,
                              input logic [127:0] d);
        if (rst) begin
            m_pc = 32'h0; m_wait = 1'b0; m_have = 1'b0;
            for (int k = 0; k < 4; k++) m_words[k] = 32'h0;
        end else if (jbv) begin
            m_pc = ja & 32'hFFFF_FFFC; m_wait = 1'b1; m_have = 1'b0;
        end else if (m_wait) begin
            if (dv) begin
                for (int k = 0; k < 4; k++) m_words[k] = d[32*k +: 32];
                m_wait = 1'b0; m_have = 1'b1;
            end
        end else if (m_have) begin
            if (!full) begin
                m_pc = m_pc + 32'd4;
                if (m_pc[3:0] == 4'h0) begin
                    m_have = 1'b0; m_wait = 1'b1;
                end
            end
        end else if (!full) begin
            m_wait = 1'b1;
        end
    endtask

    // Directed table, wrap sequence, then randomized run.
    initial begin
        logic [103:0] e;
        logic [127:0] rd_line;
        logic r_rst, r_full, r_empty, r_rd, r_dv, r_jbv;
        logic [31:0] r_ja;

        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, LINE);
        tick(); tick();

        // rst full empty rd dv jbv jaddr | st rd_en abort push byp pop flush pcin pd ppc
        row(1,0,1,0,0,1,32'h5555, 0,0,0,0,0,0,0, 32'h0,    32'h0, 32'h0);
        row(0,0,1,0,0,0,32'h0,    0,0,0,0,0,0,0, 32'h0,    32'h0, 32'h0);
        row(0,0,1,0,0,0,32'h0,    1,1,0,0,0,0,0, 32'h0,    32'h0, 32'h0);
        row(0,0,1,0,0,0,32'h0,    1,1,0,0,0,0,0, 32'h0,    32'h0, 32'h0);
        row(0,0,1,0,1,0,32'h0,    1,1,0,0,0,0,0, 32'h0,    32'h0, 32'h0);
        row(0,0,1,0,0,0,32'h0,    2,0,0,1,0,0,0, 32'h0,    32'h1111_1111, 32'h0);
        row(0,0,1,0,0,0,32'h0,    2,0,0,1,0,0,0, 32'h0,    32'h2222_2222, 32'h4);
        row(0,0,1,0,0,0,32'h0,    2,0,0,1,0,0,0, 32'h0,    32'h3333_3333, 32'h8);
        row(0,0,1,0,0,0,32'h0,    2,0,0,1,0,0,0, 32'h0,    32'h4444_4444, 32'hC);
        row(0,0,1,0,0,1,32'h1008, 1,1,1,0,0,0,1, 32'h10,   32'h0, 32'h0);
        row(0,0,1,0,1,0,32'h0,    1,1,0,0,0,0,0, 32'h1000, 32'h0, 32'h0);
        row(0,0,0,1,0,0,32'h0,    2,0,0,1,0,1,0, 32'h1000, 32'h3333_3333, 32'h1008);
        row(0,0,1,0,0,0,32'h0,    2,0,0,1,0,0,0, 32'h1000, 32'h4444_4444, 32'h100C);
        row(0,0,1,0,1,0,32'h0,    1,1,0,0,0,0,0, 32'h1010, 32'h0, 32'h0);
        row(0,0,1,1,0,0,32'h0,    2,0,0,0,1,0,0, 32'h1010, 32'h1111_1111, 32'h1010);
        row(0,1,1,0,0,0,32'h0,    2,0,0,0,0,0,0, 32'h1010, 32'h0, 32'h0);
        row(0,1,0,1,0,0,32'h0,    2,0,0,0,0,1,0, 32'h1010, 32'h0, 32'h0);
        row(0,1,1,0,0,0,32'h0,    2,0,0,0,0,0,0, 32'h1010, 32'h0, 32'h0);
        row(0,0,1,0,0,0,32'h0,    2,0,0,1,0,0,0, 32'h1010, 32'h2222_2222, 32'h1014);
        row(0,0,1,0,0,0,32'h0,    2,0,0,1,0,0,0, 32'h1010, 32'h3333_3333, 32'h1018);
        row(0,0,1,0,0,0,32'h0,    2,0,0,1,0,0,0, 32'h1010, 32'h4444_4444, 32'h101C);
        row(0,0,1,0,1,1,32'h2344, 1,1,1,0,0,0,1, 32'h1020, 32'h0, 32'h0);
        row(0,0,1,0,1,0,32'h0,    1,1,0,0,0,0,0, 32'h2340, 32'h0, 32'h0);
        row(0,0,1,0,0,0,32'h0,    2,0,0,1,0,0,0, 32'h2340, 32'h2222_2222, 32'h2344);
        row(0,1,0,1,0,1,32'h40,   2,0,0,0,0,0,1, 32'h2340, 32'h0, 32'h0);
        row(0,1,1,0,0,0,32'h0,    1,1,0,0,0,0,0, 32'h40,   32'h0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].full, vecs[i].empty, vecs[i].rd,
                  vecs[i].dv, vecs[i].jbv, vecs[i].jaddr, LINE);
            @(negedge clk);
            chk($sformatf("vec%0d", i), act_a(),
                pk(vecs[i].st, vecs[i].rd_en, vecs[i].abort, vecs[i].push,
                   vecs[i].byp, vecs[i].pop, vecs[i].flush, vecs[i].pcin,
                   vecs[i].pd, vecs[i].ppc));
            tick();
        end

        // Wrap-around: instance B resets to FFFF_FFF0 and drains one line.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, LINE);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, LINE);
        @(negedge clk);
        chk("wrap_idle", act_b(), pk(2'd0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0, 32'h0));
        tick();
        dout_valid = 1'b1;
        @(negedge clk);
        chk("wrap_req", act_b(), pk(2'd1, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0, 32'h0));
        tick();
        dout_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("wrap_w%0d", k), act_b(),
                pk(2'd2, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, LINE[32*k +: 32],
                   32'hFFFF_FFF0 + 32'(4 * k)));
            tick();
        end
        @(negedge clk);
        chk("wrap_next", act_b(), pk(2'd1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
        tick();

        // Randomized run against the model; the first cycle is a reset.
        for (int c = 0; c < 3000; c++) begin
            r_rst   = (c == 0) || ($urandom_range(199) == 0);
            r_full  = ($urandom_range(3) == 0);
            r_empty = $urandom_range(1);
            r_rd    = $urandom_range(1);
            r_dv    = ($urandom_range(2) == 0);
            r_jbv   = ($urandom_range(19) == 0);
            r_ja    = $urandom;
            rd_line = {$urandom, $urandom, $urandom, $urandom};
            drive(r_rst, r_full, r_empty, r_rd, r_dv, r_jbv, r_ja, rd_line);
            @(negedge clk);
            if (c > 0) begin
                e = model_exp(r_rst, r_full, r_empty, r_rd, r_jbv);
                chk($sformatf("rand%0d", c), act_a(), e);
            end
            model_step(r_rst, r_full, r_dv, r_jbv, r_ja, rd_line);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifq_fetch_seq.md
IFQ_FETCH_SEQ -- requirements
Module: ifq_fetch_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the fetch address loaded on reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  reset, synchronous and active-high.
REQ-004 pc_in  out  32  cache line address {fetch_pc[31:4],4'b0000}.
REQ-005 cache_rd_en  out  1  cache read request, held until dout_valid.
REQ-006 cache_abort  out  1  cancels the outstanding cache request.
REQ-007 dout  in  128  returned cache line; word k is dout[32k+31:32k].
REQ-008 dout_valid  in  1  dout is valid this cycle.
REQ-009 push  out  1  write push_data and push_pc into the FIFO.
REQ-010 push_data  out  32  instruction word selected from the line buffer.
REQ-011 push_pc  out  32  byte address of push_data.
REQ-012 fifo_full  in  1  FIFO full flag.
REQ-013 fifo_empty  in  1  FIFO empty flag.
REQ-014 inst_rd_en  in  1  dispatch read request.
REQ-015 pop  out  1  FIFO read strobe.
REQ-016 bypass  out  1  dispatch SHALL take push_data and push_pc directly instead of the FIFO head.
REQ-017 jmp_branch_address  in  32  redirect target.
REQ-018 jmp_branch_valid  in  1  redirect request.
REQ-019 flush  out  1  clears the FIFO.
REQ-020 state  out  2  FSM state: IDLE=0, REQ=1, DRAIN=2.

Function
REQ-021 Internal registers: fetch_pc[31:0], line_buf[127:0] and word index idx[1:0]; idx SHALL always equal fetch_pc[3:2].
REQ-022 IDLE: cache_rd_en=0; if fifo_full=0, the next state SHALL be REQ.
REQ-023 REQ: cache_rd_en=1 and pc_in stable; on dout_valid=1, capture dout into line_buf and go to DRAIN next cycle; otherwise stay in REQ.
REQ-024 DRAIN, fifo_full=0: the block SHALL deliver push_data=line_buf word idx with push_pc=fetch_pc, then fetch_pc += 4.
REQ-025 DRAIN, fifo_full=1: the block SHALL stall with push=0, bypass=0 and fetch_pc held.
REQ-026 DRAIN after delivering word 3: next state SHALL be REQ if fifo_full=0, else IDLE.
REQ-027 DRAIN ordering: words SHALL be delivered in order idx..3, one per cycle, and words below the entry idx SHALL be skipped.
REQ-028 Bypass, in DRAIN with delivery allowed: if fifo_empty=1 and inst_rd_en=1, then bypass=1 and push=0, and the word still counts as delivered; otherwise bypass=0 and push=1.
REQ-029 pop = inst_rd_en & ~fifo_empty & ~jmp_branch_valid; combinational.
REQ-030 Latency: dout_valid in REQ at cycle t SHALL give the first push or bypass at cycle t+1.
REQ-031 Redirect: jmp_branch_valid=1 has highest priority in every state.
- flush=1 combinationally in the same cycle.
- push, bypass and pop forced to 0 that cycle.
- dout_valid ignored that cycle.
- fetch_pc <= {jmp_branch_address[31:2],2'b00}; next state REQ.
REQ-032 cache_abort SHALL be 1 only when jmp_branch_valid=1 and state=REQ; the new request SHALL be issued the following cycle.
REQ-033 fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
REQ-034 Redirect while fifo_full=1 SHALL still enter REQ, because flush empties the FIFO.
REQ-035 push, push_data, push_pc, bypass, pop and flush are combinational from state, line_buf, fetch_pc and the inputs; cache_rd_en and pc_in depend on registers only.

Reset
REQ-036 reset=1 SHALL force the following at the next edge, regardless of state or pending dout_valid:
- state=IDLE, fetch_pc=RESET_PC, line_buf=0;
- cache_rd_en=0, cache_abort=0, push=0, bypass=0, pop=0, flush=0.
REQ-037 During reset, all inputs SHALL be ignored, including jmp_branch_valid.

Verification
REQ-038 Cold start: reset, fifo_full=0, dout_valid in the 3rd REQ cycle with dout=128'h4444_4444_3333_3333_2222_2222_1111_1111 -> pc_in=0; push_data 11111111,22222222,33333333,44444444 on 4 consecutive cycles with push_pc 0,4,8,C; then REQ with pc_in=0x10.
REQ-039 Redirect to 0x0000_1008 while in REQ -> cache_abort=1 and flush=1 for one cycle; next cycle pc_in=0x1000; after dout_valid only words 2 and 3 are pushed, with push_pc 0x1008 and 0x100C.
REQ-040 fifo_full=1 asserted mid-DRAIN at word 1 for 3 cycles -> push=0 for those 3 cycles; word 1 is then delivered with unchanged push_pc; no word lost or duplicated.
REQ-041 Bypass: fifo_empty=1, inst_rd_en=1 in the first DRAIN cycle -> bypass=1, push=0, pop=0; subsequent words with fifo_empty=0 -> push=1.
REQ-042 Redirect and dout_valid in the same REQ cycle -> line discarded, no push; next request pc_in = {target[31:4],4'b0}.
REQ-043 Wrap: RESET_PC=32'hFFFF_FFF0, full line drained -> push_pc F0,F4,F8,FC (top bits all F); next pc_in=0x0000_0000.
